// File: rtl/vmem_pkg.sv
// Shared video-memory definitions: raster defaults, address layout and fill FSM states.
// Writer and scan-out both use vmem_addr() so the pixel address format lives in one place.
package vmem_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_COLOR_W  = 12;
  localparam int VADDR_W      = 19;
  localparam int COORD_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  function automatic logic [VADDR_W-1:0] vmem_addr(input logic [COORD_W-1:0] x,
                                                   input logic [8:0]         y);
    return {x, y};
  endfunction

endpackage

// File: rtl/rect_scan.sv
// Raster counter for one rectangle: loads bounds and origin, then steps row-major, x inner.
// Holds on the last pixel so neither counter can run past the clipped corner.
module rect_scan
  import vmem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [COORD_W-1:0] i_xl,
  input  logic [COORD_W-1:0] i_xh,
  input  logic [COORD_W-1:0] i_yl,
  input  logic [COORD_W-1:0] i_yh,
  output logic [VADDR_W-1:0] o_addr,
  output logic               o_last
);

  logic [COORD_W-1:0] r_xl;
  logic [COORD_W-1:0] r_xh;
  logic [COORD_W-1:0] r_yh;
  logic [COORD_W-1:0] r_cx;
  logic [COORD_W-1:0] r_cy;
  logic               w_row_end;

  assign w_row_end = (r_cx == r_xh);
  assign o_last    = w_row_end && (r_cy == r_yh);
  assign o_addr    = vmem_addr(r_cx, r_cy[8:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xl <= '0;
      r_xh <= '0;
      r_yh <= '0;
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_load) begin
      r_xl <= i_xl;
      r_xh <= i_xh;
      r_yh <= i_yh;
      r_cx <= i_xl;
      r_cy <= i_yl;
    end else if (i_step && !o_last) begin
      if (w_row_end) begin
        r_cx <= r_xl;
        r_cy <= r_cy + 10'd1;
      end else begin
        r_cx <= r_cx + 10'd1;
      end
    end
  end

endmodule

// File: rtl/vmem_fill.sv
// Solid rectangle fill into video memory, one pixel per clock, corners sorted and clipped.
// One command at a time: cmd_ready only in IDLE; inputs seen while busy are ignored.
module vmem_fill
  import vmem_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int COLOR_W  = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [9:0]         x0,
  input  logic [9:0]         x1,
  input  logic [9:0]         y0,
  input  logic [9:0]         y1,
  input  logic [COLOR_W-1:0] color,
  output logic               we,
  output logic [VADDR_W-1:0] waddr,
  output logic [COLOR_W-1:0] wdata,
  output logic               busy,
  output logic               done
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

  fill_state_t        r_state;
  fill_state_t        w_state_nxt;

  logic [COORD_W-1:0] r_x0;
  logic [COORD_W-1:0] r_x1;
  logic [COORD_W-1:0] r_y0;
  logic [COORD_W-1:0] r_y1;
  logic [COLOR_W-1:0] r_color;

  logic               r_cmd_ready;
  logic               r_we;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic [COORD_W-1:0] w_xl;
  logic [COORD_W-1:0] w_xh_raw;
  logic [COORD_W-1:0] w_xh;
  logic [COORD_W-1:0] w_yl;
  logic [COORD_W-1:0] w_yh_raw;
  logic [COORD_W-1:0] w_yh;
  logic               w_offscreen;
  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [VADDR_W-1:0] w_addr;

  assign w_accept = cmd_valid && r_cmd_ready;

  // Sort on the full 10-bit values, then clip only the high corner.
  assign w_xl        = (r_x0 < r_x1) ? r_x0 : r_x1;
  assign w_xh_raw    = (r_x0 < r_x1) ? r_x1 : r_x0;
  assign w_yl        = (r_y0 < r_y1) ? r_y0 : r_y1;
  assign w_yh_raw    = (r_y0 < r_y1) ? r_y1 : r_y0;
  assign w_xh        = (w_xh_raw > X_MAX) ? X_MAX : w_xh_raw;
  assign w_yh        = (w_yh_raw > Y_MAX) ? Y_MAX : w_yh_raw;
  assign w_offscreen = (w_xl > X_MAX) || (w_yl > Y_MAX);

  rect_scan u_scan (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_xl   (w_xl),
    .i_xh   (w_xh),
    .i_yl   (w_yl),
    .i_yh   (w_yh),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        if (w_offscreen) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0    <= '0;
      r_x1    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_color <= '0;
    end else if (w_accept) begin
      r_x0    <= x0;
      r_x1    <= x1;
      r_y0    <= y0;
      r_y1    <= y1;
      r_color <= color;
    end
  end

  // Status flags are registered copies of the next-state decode so they align with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_ready <= 1'b1;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_we        <= (w_state_nxt == ST_FILL);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign we        = r_we;
  assign waddr     = w_addr;
  assign wdata     = r_color;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_vmem_fill.sv
// Directed bench for vmem_fill: write order, latency, clipping, held valid and mid-fill reset.
module tb_vmem_fill;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  x0, x1, y0, y1;
  logic [11:0] color;
  logic        we;
  logic [18:0] waddr;
  logic [11:0] wdata;
  logic        busy;
  logic        done;

  int          n_chk;
  int          n_err;
  int          cyc;
  int          done_cnt;
  int          ready_hi;
  logic [18:0] wq_addr[$];
  logic [11:0] wq_dat[$];
  int          wq_cyc[$];

  vmem_fill dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .x0        (x0),
    .x1        (x1),
    .y0        (y0),
    .y1        (y1),
    .color     (color),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        wq_addr.push_back(waddr);
        wq_dat.push_back(wdata);
        wq_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] exp_addr(input int x, input int y);
    return 19'((x * 512) + (y % 512));
  endfunction

  task automatic clear_q();
    wq_addr.delete();
    wq_dat.delete();
    wq_cyc.delete();
  endtask

  // Present one command at a negedge once ready; returns the accept cycle T at negedge T+1.
  task automatic send(input int ax0, input int ay0, input int ax1, input int ay1,
                      input logic [11:0] acol, output int t_acc);
    int n;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1); color = acol;
    cmd_valid = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("setup_busy", {31'd0, busy}, 32'd1);
    chk("setup_ready", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic wait_done(input int budget, output int dc);
    bit seen;
    seen = 1'b0;
    dc = -1;
    ready_hi = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready) ready_hi++;
      if (done) begin
        seen = 1'b1;
        dc = cyc;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Compare captured writes with a row-major walk over [xl..xh] x [yl..yh].
  task automatic check_rect(input string tag, input int xl, input int xh, input int yl,
                            input int yh, input logic [11:0] col, input int t_acc);
    int k, bad_a, bad_d, bad_t;
    k = 0; bad_a = 0; bad_d = 0; bad_t = 0;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        if (k < wq_addr.size()) begin
          if (wq_addr[k] !== exp_addr(x, y)) bad_a++;
          if (wq_dat[k] !== col) bad_d++;
          if (wq_cyc[k] != t_acc + 2 + k) bad_t++;
        end
        k++;
      end
    end
    chk({tag, "_count"}, wq_addr.size(), k);
    chk({tag, "_addr_bad"}, bad_a, 0);
    chk({tag, "_data_bad"}, bad_d, 0);
    chk({tag, "_cycle_bad"}, bad_t, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, dc, t1, n, dn0, oob;
    n_chk = 0; n_err = 0; cyc = 0; done_cnt = 0;
    rst = 1'b1; cmd_valid = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", {13'd0, waddr}, 32'd0);
    chk("rst_wdata", {20'd0, wdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic 3x2 rectangle
    clear_q();
    send(10, 20, 12, 21, 12'hF00, t);
    wait_done(50, dc);
    check_rect("basic", 10, 12, 20, 21, 12'hF00, t);
    if (wq_addr.size() > 0) chk("basic_first_addr", {13'd0, wq_addr[0]}, {13'd0, 10'd10, 9'd20});
    chk("basic_done_cyc", dc, t + 8);
    @(negedge clk);
    chk("basic_ready_back", {31'd0, cmd_ready}, 32'd1);

    // Reversed corners
    clear_q();
    send(12, 21, 10, 20, 12'h0A5, t);
    wait_done(50, dc);
    check_rect("rev", 10, 12, 20, 21, 12'h0A5, t);
    chk("rev_done_cyc", dc, t + 8);

    // Clipped to the bottom-right corner
    clear_q();
    send(630, 470, 900, 900, 12'h0F0, t);
    wait_done(300, dc);
    check_rect("clip", 630, 639, 470, 479, 12'h0F0, t);
    oob = 0;
    foreach (wq_addr[i]) if (wq_addr[i][18:9] > 10'd639 || wq_addr[i][8:0] > 9'd479) oob++;
    chk("clip_oob", oob, 0);
    if (wq_addr.size() > 0) chk("clip_last", {13'd0, wq_addr[wq_addr.size()-1]}, {13'd0, exp_addr(639, 479)});
    chk("clip_done_cyc", dc, t + 102);

    // Fully off-screen
    clear_q();
    send(700, 0, 800, 5, 12'h00F, t);
    wait_done(20, dc);
    chk("off_writes", wq_addr.size(), 0);
    chk("off_done_cyc", dc, t + 2);

    // Wide band across the full width, top rows
    clear_q();
    send(639, 9, 0, 0, 12'h000, t);
    wait_done(7000, dc);
    check_rect("band", 0, 639, 0, 9, 12'h000, t);
    chk("band_ready_low", ready_hi, 0);
    chk("band_done_cyc", dc, t + 6402);

    // Single pixel with cmd_valid held high
    clear_q();
    @(negedge clk);
    x0 = 10'd5; y0 = 10'd5; x1 = 10'd5; y1 = 10'd5; color = 12'h777;
    cmd_valid = 1'b1;
    t = cyc;
    t1 = -1; n = 0;
    while (t1 < 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (cmd_ready) t1 = cyc;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_second_accept", t1 - t, 4);
    wait_done(20, dc);
    chk("hold_writes", wq_addr.size(), 2);
    if (wq_addr.size() > 0) chk("hold_addr", {13'd0, wq_addr[0]}, {13'd0, exp_addr(5, 5)});
    if (wq_cyc.size() > 1) chk("hold_second_write_cyc", wq_cyc[1], t1 + 2);

    // Reset in the middle of a 10x10 fill
    repeat (2) @(negedge clk);
    clear_q();
    send(100, 100, 109, 109, 12'hABC, t);
    repeat (20) @(negedge clk);
    chk("mid_we_before", {31'd0, we}, 32'd1);
    dn0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("mid_we_async", {31'd0, we}, 32'd0);
    chk("mid_ready_async", {31'd0, cmd_ready}, 32'd1);
    chk("mid_busy_async", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    chk("mid_no_done", done_cnt, dn0);

    clear_q();
    send(6, 5, 5, 6, 12'h321, t);
    wait_done(30, dc);
    check_rect("after_rst", 5, 6, 5, 6, 12'h321, t);
    chk("after_rst_done_cyc", dc, t + 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vmem_fill.md
# vmem_fill

Rectangle-fill engine that writes solid-colour pixels into video memory, one pixel per clock. Sits directly upstream of the display controller's memory: it drives the memory write port that the scan-out path reads. It uses the same pixel addressing as scan-out, `{x[9:0], y[8:0]}`. Software or higher-level drawing logic issues one command per rectangle; a full-screen rectangle acts as a screen clear.

## Interface

Parameters:
- `H_ACTIVE`, default 640: visible width; x is clipped to `H_ACTIVE-1`.
- `V_ACTIVE`, default 480: visible height; y is clipped to `V_ACTIVE-1`.
- `COLOR_W`, default 12: pixel width, as 4:4:4 RGB (`{r,g,b}`).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, same domain as the video-memory write port.
- `rst` in 1: asynchronous active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle and able to accept a command.
- `x0`, `x1` in 10 each: horizontal corners, any order.
- `y0`, `y1` in 10 each: vertical corners, any order.
- `color` in `COLOR_W`: fill value.
- `we` out 1: memory write enable.
- `waddr` out 19: write address `{x, y[8:0]}`.
- `wdata` out `COLOR_W`: write data.
- `busy` out 1: high from the SETUP state through the DONE state.
- `done` out 1: one-cycle pulse when a command completes.

## Operation

- FSM states: IDLE, SETUP, FILL, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, latch all of `x0`, `x1`, `y0`, `y1` and `color`, then go to SETUP.
- **SETUP** (1 cycle)
  - Sort the corners: xl=min(x0,x1), xh=max(x0,x1); yl and yh likewise.
  - Clip: xh=min(xh, H_ACTIVE-1), yh=min(yh, V_ACTIVE-1).
  - If xl>H_ACTIVE-1 or yl>V_ACTIVE-1 the rectangle is fully off-screen: go to DONE with no writes.
  - Otherwise load cx=xl, cy=yl and go to FILL.
- **FILL**
  - Every cycle: `we`=1, `waddr`={cx, cy[8:0]}, `wdata`=latched color.
  - Scan order is row-major with x as the inner loop.
  - If cx==xh: cx<=xl and cy<=cy+1; otherwise cx<=cx+1.
  - On the write where cx==xh and cy==yh, go to DONE.
- **DONE** (1 cycle): `done`=1, then return to IDLE.
- Compare against the full 10-bit values before truncating y to 9 bits. No counter may wrap past 1023 (e.g. xh=1023 never occurs after clipping).
- Inputs presented while not IDLE are ignored. There is no queueing.
- Degenerate rectangles (x0==x1 and/or y0==y1) are legal and write a line or a single pixel.

## Timing

- Reset values: `cmd_ready`=1, `we`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0, state IDLE.
- Reset asserted mid-FILL drops `we` immediately (asynchronously) and abandons the command. No `done` is produced.
- Command accepted at cycle T:
  - T+1: SETUP, `busy`=1, `cmd_ready`=0.
  - T+2: first write.
  - With N=(xh-xl+1)*(yh-yl+1) after clipping, the last write is at T+1+N.
  - `done` is at T+2+N.
  - `cmd_ready`=1 again at T+3+N.
- Off-screen command: `done` at T+2 with no writes.
- All outputs are registered.
- `cmd_valid` held high through DONE does not cause a second acceptance until the engine is back in IDLE. Back-to-back commands therefore have a minimum spacing of N+3 cycles.

## Structure

- Shared package `vmem_pkg` holds:
  - `H_ACTIVE`/`V_ACTIVE` defaults,
  - `VADDR_W`=19,
  - `COLOR_W`,
  - the FSM enum `fill_state_t`,
  - function `vmem_addr(x,y)` returning `{x, y[8:0]}`, so the writer and scan-out share one address definition.
- One natural sub-module, `rect_scan`: the cx/cy raster counter with load/step/last outputs. Everything else lives in `vmem_fill`.

## Test plan

- Reset, then cmd (x0=10,y0=20,x1=12,y1=21,color=12'hF00) -> exactly 6 writes in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21).
  - `waddr` for (10,20) = {10'd10, 9'd20}.
  - `wdata`=F00.
  - `done` at T+8.
- Reversed corners (x0=12,x1=10,y0=21,y1=20) -> write sequence identical to the first test.
- Clipping: (630,470)-(900,900) -> 10×10=100 writes, last at (639,479), no address with x>639 or y>479. Off-screen (700,0)-(800,5) -> zero writes, `done` at T+2.
- Full clear: (0,0)-(639,479), color 0 -> 307200 writes, each address exactly once; `cmd_ready` stays low throughout; `done` at T+307202.
- Single pixel (5,5)-(5,5) -> one write; `cmd_valid` held high gives the second acceptance at T+4.
- Assert `rst` during FILL of a 100-pixel rectangle -> `we`=0 in the same cycle, no `done`, `cmd_ready`=1; a new command after reset runs normally.
